// File: rtl/sd_card_dat_responder.sv
// SD card DAT0 line responder: receives host write blocks (CRC status token + busy) and
// transmits read blocks. Define SD_CARD_DAT_CRC_EN to compute/check/transmit CRC16.
module sd_card_dat_responder #(
    parameter int unsigned BLOCK_WORDS = 1,
    parameter int unsigned TIMEOUT     = 64,
    parameter int unsigned BUSY_CYCLES = 8
) (
    input  logic        iClock,
    input  logic        iReset,
    input  logic        iStart,
    input  logic        iWriteRead,
    input  logic        iData_pin,
    output logic        oData_pin,
    output logic        oData_oe,
    input  logic [31:0] iData_tx,
    input  logic        iTx_valid,
    output logic        oTx_ready,
    output logic [31:0] oData_rx,
    output logic        oRx_valid,
    output logic        oBusy,
    output logic        oDone,
    output logic [1:0]  oError
);

`ifdef SD_CARD_DAT_CRC_EN
    localparam bit CRC_EN = 1'b1;
`else
    localparam bit CRC_EN = 1'b0;
`endif

    localparam int unsigned DATA_BITS = BLOCK_WORDS * 32;
    localparam int unsigned MAX_A     = (TIMEOUT > DATA_BITS) ? TIMEOUT : DATA_BITS;
    localparam int unsigned MAX_CNT   = (BUSY_CYCLES > MAX_A) ? BUSY_CYCLES : MAX_A;
    localparam int unsigned CNT_W     = $clog2(MAX_CNT + 1);

    typedef enum logic [3:0] {
        StIdle, StWaitStart, StRxData, StRxCrc, StRxEnd, StTurn, StToken, StBusy,
        StTxStart, StTxData, StTxCrc, StTxEnd
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [31:0]        shreg_q, shreg_d;
    logic [15:0]        crc_q, crc_d;
    logic [15:0]        crc_rx_q, crc_rx_d;
    logic [1:0]         status_q, status_d;
    logic [31:0]        rx_data_q, rx_data_d;
    logic               rx_valid_q, rx_valid_d;
    logic               done_q, done_d;
    logic [1:0]         error_q, error_d;
    logic               data_pin, data_oe, tx_ready;
    logic [4:0]         token;

    // Serial CRC16-CCITT step (x^16 + x^12 + x^5 + 1), MSB first.
    function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
        logic fb;
        fb = c[15] ^ b;
        return {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
    endfunction

    assign token = (status_q == 2'b00) ? 5'b00101 : 5'b01011;

    always_comb begin
        state_d    = state_q;
        cnt_d      = cnt_q;
        shreg_d    = shreg_q;
        crc_d      = crc_q;
        crc_rx_d   = crc_rx_q;
        status_d   = status_q;
        rx_data_d  = rx_data_q;
        rx_valid_d = 1'b0;
        done_d     = 1'b0;
        error_d    = error_q;
        data_oe    = 1'b0;
        data_pin   = 1'b1;
        tx_ready   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (iStart) begin
                    cnt_d    = '0;
                    crc_d    = '0;
                    status_d = 2'b00;
                    state_d  = iWriteRead ? StWaitStart : StTxStart;
                end
            end
            StWaitStart: begin
                if (!iData_pin) begin
                    cnt_d   = '0;
                    state_d = StRxData;
                end else if (cnt_q == CNT_W'(TIMEOUT - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    error_d = 2'b11;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRxData: begin
                shreg_d = {shreg_q[30:0], iData_pin};
                if (CRC_EN) crc_d = crc_step(crc_q, iData_pin);
                if (cnt_q[4:0] == 5'd31) begin
                    rx_data_d  = shreg_d;
                    rx_valid_d = 1'b1;
                end
                if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = StRxCrc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRxCrc: begin
                crc_rx_d = {crc_rx_q[14:0], iData_pin};
                if (cnt_q == CNT_W'(15)) begin
                    cnt_d   = '0;
                    state_d = StRxEnd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StRxEnd: begin
                // A broken end bit outranks a CRC mismatch.
                if (!iData_pin)                      status_d = 2'b10;
                else if (CRC_EN && crc_rx_q != crc_q) status_d = 2'b01;
                else                                 status_d = 2'b00;
                cnt_d   = '0;
                state_d = StTurn;
            end
            StTurn: begin
                if (cnt_q == CNT_W'(1)) begin
                    cnt_d   = '0;
                    state_d = StToken;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StToken: begin
                data_oe  = 1'b1;
                data_pin = token[3'd4 - cnt_q[2:0]];
                if (cnt_q == CNT_W'(4)) begin
                    cnt_d   = '0;
                    state_d = StBusy;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StBusy: begin
                data_oe  = 1'b1;
                data_pin = 1'b0;
                if (cnt_q == CNT_W'(BUSY_CYCLES - 1)) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    error_d = status_q;
                    cnt_d   = '0;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTxStart: begin
                data_oe  = 1'b1;
                data_pin = 1'b0;
                tx_ready = 1'b1;
                cnt_d    = '0;
                if (!iTx_valid) begin
                    state_d = StIdle;
                    done_d  = 1'b1;
                    error_d = 2'b11;
                end else begin
                    shreg_d = iData_tx;
                    state_d = StTxData;
                end
            end
            StTxData: begin
                data_oe  = 1'b1;
                data_pin = shreg_q[31];
                shreg_d  = {shreg_q[30:0], 1'b0};
                if (CRC_EN) crc_d = crc_step(crc_q, shreg_q[31]);
                if (cnt_q == CNT_W'(DATA_BITS - 1)) begin
                    cnt_d   = '0;
                    state_d = StTxCrc;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                    // Request the next word while its predecessor's last bit is on the line.
                    if (cnt_q[4:0] == 5'd31) begin
                        tx_ready = 1'b1;
                        if (!iTx_valid) begin
                            state_d = StIdle;
                            done_d  = 1'b1;
                            error_d = 2'b11;
                            cnt_d   = '0;
                        end else begin
                            shreg_d = iData_tx;
                        end
                    end
                end
            end
            StTxCrc: begin
                data_oe  = 1'b1;
                data_pin = CRC_EN ? crc_q[15] : 1'b0;
                crc_d    = {crc_q[14:0], 1'b0};
                if (cnt_q == CNT_W'(15)) begin
                    cnt_d   = '0;
                    state_d = StTxEnd;
                end else begin
                    cnt_d = cnt_q + 1'b1;
                end
            end
            StTxEnd: begin
                data_oe  = 1'b1;
                data_pin = 1'b1;
                state_d  = StIdle;
                done_d   = 1'b1;
                error_d  = 2'b00;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge iClock or negedge iReset) begin
        if (!iReset) begin
            state_q    <= StIdle;
            cnt_q      <= '0;
            shreg_q    <= '0;
            crc_q      <= '0;
            crc_rx_q   <= '0;
            status_q   <= 2'b00;
            rx_data_q  <= '0;
            rx_valid_q <= 1'b0;
            done_q     <= 1'b0;
            error_q    <= 2'b00;
        end else begin
            state_q    <= state_d;
            cnt_q      <= cnt_d;
            shreg_q    <= shreg_d;
            crc_q      <= crc_d;
            crc_rx_q   <= crc_rx_d;
            status_q   <= status_d;
            rx_data_q  <= rx_data_d;
            rx_valid_q <= rx_valid_d;
            done_q     <= done_d;
            error_q    <= error_d;
        end
    end

    assign oData_pin = data_pin;
    assign oData_oe  = data_oe;
    assign oTx_ready = tx_ready;
    assign oData_rx  = rx_data_q;
    assign oRx_valid = rx_valid_q;
    assign oBusy     = (state_q != StIdle);
    assign oDone     = done_q;
    assign oError    = error_q;

endmodule
